frame_seq_ctrl: RTL and testbench

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

---
 rtl/frame_seq_ctrl.sv | 118 +++++++++++
 tb/tb_frame_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: loads one frame of bytes from the UART rx FIFO into the frame RAM, then replays it to the UART tx FIFO.
// Latency: LOAD moves 1 byte/cycle while the rx FIFO has data; SEND moves 1 byte per 2 cycles (RAM read, then push).
// Backpressure: rx_empty stalls LOAD and tx_full stalls SEND_WR indefinitely, with address held; btn_tick is ignored while busy.
// Build option: define FRAME_SEQ_INVERT_EN to transmit the bitwise inverse of each stored byte (8'hFF - x).
module frame_seq_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_tick,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              rd_uart,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done_tick
);

  // Index of the final byte; with FRAME_LEN = 2^ADDR_W this is all-ones,
  // so the counter never needs to wrap inside a frame.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND_RD = 3'd2,
    SEND_WR = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and byte counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode; all strobes are single-cycle by construction.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_uart   = 1'b0;
    ram_we    = 1'b0;
    wr_uart   = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_tick) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // Pop and write in the same cycle: the FIFO head byte goes straight into RAM.
        if (!rx_empty) begin
          rd_uart = 1'b1;
          ram_we  = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = SEND_RD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SEND_RD: begin
        // Address is presented this cycle; RAM data appears in SEND_WR.
        state_d = SEND_WR;
      end
      SEND_WR: begin
        // Address stays put while stalled, so ram_rdata remains valid.
        if (!tx_full) begin
          wr_uart = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SEND_RD;
          end
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
        cnt_d     = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ram_addr  = cnt_q;
  assign ram_wdata = rx_data;
  assign busy      = (state_q != IDLE);

`ifdef FRAME_SEQ_INVERT_EN
  assign tx_data = 8'hFF - ram_rdata;
`else
  assign tx_data = ram_rdata;
`endif

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl: FRAME_LEN=4/ADDR_W=2 main instance plus a FRAME_LEN=1 instance.
// Bench models a 16-deep rx FIFO, a synchronous-read frame RAM and a tx push log per instance.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
module tb_frame_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main instance (FRAME_LEN=4) ----------------
  logic       reset, btn_tick, rx_empty, rd_uart, ram_we, tx_full, wr_uart, busy, done_tick;
  logic [7:0] rx_data, ram_wdata, ram_rdata, tx_data;
  logic [1:0] ram_addr;

  frame_seq_ctrl #(.ADDR_W(2), .FRAME_LEN(4)) dut (
    .clk(clk), .reset(reset), .btn_tick(btn_tick),
    .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tx_full(tx_full), .wr_uart(wr_uart), .tx_data(tx_data),
    .busy(busy), .done_tick(done_tick)
  );

  logic [7:0] rx_mem [16];
  int         rx_rd = 0;
  int         rx_wr = 0;
  logic       rx_hold;
  assign rx_empty = rx_hold || (rx_rd == rx_wr);
  assign rx_data  = rx_mem[rx_rd[3:0]];

  logic [7:0] ram [4];
  logic [7:0] tx_log [16];
  int pops = 0, pushes = 0, done_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    if (rd_uart) begin
      pops <= pops + 1;
      if (!rx_empty) rx_rd <= rx_rd + 1;
    end
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    if (wr_uart) begin
      tx_log[pushes[3:0]] <= tx_data;
      pushes <= pushes + 1;
    end
    if (done_tick) done_cnt <= done_cnt + 1;
    if (rd_uart && wr_uart) both_cnt <= both_cnt + 1;
  end

  // ---------------- FRAME_LEN=1 instance ----------------
  logic       btn1, rx_empty1, rd1, we1, tx_full1, wr1, busy1, done1;
  logic [7:0] rx_data1, wdata1, rdata1, tx1;
  logic [1:0] addr1;

  frame_seq_ctrl #(.ADDR_W(2), .FRAME_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .btn_tick(btn1),
    .rx_empty(rx_empty1), .rx_data(rx_data1), .rd_uart(rd1),
    .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1), .ram_rdata(rdata1),
    .tx_full(tx_full1), .wr_uart(wr1), .tx_data(tx1),
    .busy(busy1), .done_tick(done1)
  );

  logic [7:0] ram1;
  int pops1 = 0, pushes1 = 0, done1_cnt = 0;
  always @(posedge clk) begin
    if (we1) ram1 <= wdata1;
    rdata1 <= ram1;
    if (rd1) pops1 <= pops1 + 1;
    if (wr1) pushes1 <= pushes1 + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] fx(input logic [7:0] x);
`ifdef FRAME_SEQ_INVERT_EN
    return 8'hFF - x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic e_rd, input logic e_we, input logic e_wr,
                         input logic [1:0] e_addr, input logic e_busy, input logic e_done);
    chk({tag, " rd_uart"},   rd_uart,   e_rd);
    chk({tag, " ram_we"},    ram_we,    e_we);
    chk({tag, " wr_uart"},   wr_uart,   e_wr);
    chk({tag, " ram_addr"},  ram_addr,  e_addr);
    chk({tag, " busy"},      busy,      e_busy);
    chk({tag, " done_tick"}, done_tick, e_done);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_mem[rx_wr[3:0]] = b;
    rx_wr++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] e1 [4];
    logic [7:0] e2 [4];
    e1 = '{8'h10, 8'h20, 8'h30, 8'h40};
    e2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    reset = 1'b1; btn_tick = 1'b0; rx_hold = 1'b0; tx_full = 1'b0;
    btn1 = 1'b0; rx_empty1 = 1'b1; rx_data1 = 8'h7F; tx_full1 = 1'b0;
    repeat (2) cyc;
    #1;
    exp_out("reset", 0, 0, 0, 2'd0, 0, 0);
    chk("reset dut1 busy", busy1, 1'b0);
    reset = 1'b0;

    // Frame 1: load with a 5-cycle rx stall, send with a 3-cycle tx stall, stray btn_ticks.
    rx_push(8'h10); rx_push(8'h20); rx_push(8'h30); rx_push(8'h40);
    cyc; btn_tick = 1'b1; #1;
    exp_out("idle", 0, 0, 0, 2'd0, 0, 0);
    cyc; btn_tick = 1'b0; #1;
    exp_out("ld0", 1, 1, 0, 2'd0, 1, 0);
    chk("ld0 wdata", ram_wdata, 8'h10);
    cyc; #1;
    exp_out("ld1", 1, 1, 0, 2'd1, 1, 0);
    chk("ld1 wdata", ram_wdata, 8'h20);
    cyc; rx_hold = 1'b1; #1;
    exp_out("stall", 0, 0, 0, 2'd2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc; btn_tick = (i == 1); #1;
      exp_out("stall_n", 0, 0, 0, 2'd2, 1, 0);
    end
    cyc; rx_hold = 1'b0; btn_tick = 1'b0; #1;
    exp_out("ld2", 1, 1, 0, 2'd2, 1, 0);
    chk("ld2 wdata", ram_wdata, 8'h30);
    cyc; #1;
    exp_out("ld3", 1, 1, 0, 2'd3, 1, 0);
    chk("ld3 wdata", ram_wdata, 8'h40);
    cyc; #1;
    exp_out("srd0", 0, 0, 0, 2'd0, 1, 0);
    cyc; #1;
    exp_out("swr0", 0, 0, 1, 2'd0, 1, 0);
    chk("swr0 tx_data", tx_data, fx(8'h10));
    cyc; #1;
    exp_out("srd1", 0, 0, 0, 2'd1, 1, 0);
    cyc; tx_full = 1'b1; #1;
    exp_out("swr1 full", 0, 0, 0, 2'd1, 1, 0);
    repeat (2) begin
      cyc; #1;
      exp_out("swr1 full_n", 0, 0, 0, 2'd1, 1, 0);
    end
    cyc; tx_full = 1'b0; #1;
    exp_out("swr1", 0, 0, 1, 2'd1, 1, 0);
    chk("swr1 tx_data", tx_data, fx(8'h20));
    cyc; btn_tick = 1'b1; #1;
    exp_out("srd2", 0, 0, 0, 2'd2, 1, 0);
    cyc; btn_tick = 1'b0; #1;
    exp_out("swr2", 0, 0, 1, 2'd2, 1, 0);
    chk("swr2 tx_data", tx_data, fx(8'h30));
    cyc; #1;
    exp_out("srd3", 0, 0, 0, 2'd3, 1, 0);
    cyc; #1;
    exp_out("swr3", 0, 0, 1, 2'd3, 1, 0);
    chk("swr3 tx_data", tx_data, fx(8'h40));
    cyc; #1;
    chk("done done_tick", done_tick, 1'b1);
    chk("done busy", busy, 1'b1);
    chk("done wr_uart", wr_uart, 1'b0);
    chk("done rd_uart", rd_uart, 1'b0);
    cyc; #1;
    exp_out("idle after", 0, 0, 0, 2'd0, 0, 0);
    chk("f1 pops", pops, 4);
    chk("f1 pushes", pushes, 4);
    chk("f1 done count", done_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f1 ram[%0d]", i), ram[i], e1[i]);
      chk($sformatf("f1 tx[%0d]", i), tx_log[i], fx(e1[i]));
    end

    // Frame 2: aborted by reset in SEND_RD of byte 2, then a fresh frame from address 0.
    rx_push(8'h55); rx_push(8'h66); rx_push(8'h77); rx_push(8'h88);
    cyc; btn_tick = 1'b1;
    cyc; btn_tick = 1'b0;
    repeat (3) cyc;
    repeat (5) cyc;
    #1;
    exp_out("pre-reset srd2", 0, 0, 0, 2'd2, 1, 0);
    reset = 1'b1;
    cyc; #1;
    exp_out("post reset", 0, 0, 0, 2'd0, 0, 0);
    reset = 1'b0;
    rx_push(8'hA1); rx_push(8'hB2); rx_push(8'hC3); rx_push(8'hD4);
    cyc; btn_tick = 1'b1; #1;
    chk("reload idle busy", busy, 1'b0);
    cyc; btn_tick = 1'b0; #1;
    exp_out("reload", 1, 1, 0, 2'd0, 1, 0);
    chk("reload wdata", ram_wdata, 8'hA1);
    begin
      int n;
      n = 0;
      while (!done_tick && n < 40) begin
        cyc; #1;
        n++;
      end
      chk("reload done reached", done_tick, 1'b1);
    end
    cyc; #1;
    exp_out("idle after reload", 0, 0, 0, 2'd0, 0, 0);
    chk("f3 pushes", pushes, 10);
    chk("abort no done_tick", done_cnt, 2);
    for (int i = 0; i < 4; i++)
      chk($sformatf("f3 tx[%0d]", i), tx_log[6 + i], fx(e2[i]));
    chk("rd/wr overlap", both_cnt, 0);

    // FRAME_LEN=1 instance: one pop, one push, done.
    cyc; btn1 = 1'b1; rx_empty1 = 1'b0; #1;
    chk("len1 idle busy", busy1, 1'b0);
    cyc; btn1 = 1'b0; #1;
    chk("len1 ld rd_uart", rd1, 1'b1);
    chk("len1 ld ram_we", we1, 1'b1);
    chk("len1 ld addr", addr1, 2'd0);
    chk("len1 ld wdata", wdata1, 8'h7F);
    cyc; rx_empty1 = 1'b1; #1;
    chk("len1 srd rd_uart", rd1, 1'b0);
    chk("len1 srd wr_uart", wr1, 1'b0);
    cyc; #1;
    chk("len1 swr wr_uart", wr1, 1'b1);
    chk("len1 swr tx_data", tx1, fx(8'h7F));
    cyc; #1;
    chk("len1 done_tick", done1, 1'b1);
    chk("len1 done wr_uart", wr1, 1'b0);
    cyc; #1;
    chk("len1 final busy", busy1, 1'b0);
    chk("len1 final done_tick", done1, 1'b0);
    chk("len1 pops", pops1, 1);
    chk("len1 pushes", pushes1, 1);
    chk("len1 done count", done1_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
